// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and sizing for the restoring divider block:
//               FSM state encoding, default operand width and the
//               width of the iteration counter.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default operand width in bits
    localparam int W_DEFAULT = 4;

    // The iteration counter must hold the value W without wrapping,
    // hence ceil(log2(W)) + 1 bits.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(W_DEFAULT);

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/sub_borrow.sv
`default_nettype none
// ============================================================================
// Module      : sub_borrow
// Description : Combinational N-bit subtractor A-B built as a ripple chain
//               of 1-bit full subtractors. Produces the difference and the
//               final borrow (borrow=1 means A < B as unsigned values).
// Revision    : 1.0 - initial release
// ============================================================================

// One-bit full subtractor: d = a - b - bin, with borrow out
module full_sub1 (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule : full_sub1

module sub_borrow #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    // Each stage keeps its own borrow-in/borrow-out nets so the chain is a
    // set of distinct signals rather than one vector feeding itself.
    for (genvar i = 0; i < N; i++) begin : g_bit
        logic w_bin;
        logic w_bout;

        if (i == 0) begin : g_lsb
            assign w_bin = 1'b0;
        end else begin : g_chain
            assign w_bin = g_bit[i-1].w_bout;
        end

        full_sub1 u_fs (
            .a_i    (a_i[i]),
            .b_i    (b_i[i]),
            .bin_i  (w_bin),
            .d_o    (diff_o[i]),
            .bout_o (w_bout)
        );
    end

    assign borrow_o = g_bit[N-1].w_bout;

endmodule : sub_borrow
`default_nettype wire

// File: rtl/restoring_divider4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider4_ctrl
// Description : Sequential unsigned restoring divider. One quotient bit is
//               resolved per RUN cycle using a single shared subtractor.
//               Divide-by-zero short-cuts straight to DONE with
//               quotient=all-ones, remainder=dividend and a sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider4_ctrl
    import div_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(W - 1);

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     quot_q;
    logic [W-1:0]     rem_q;
    logic             dbz_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W:0]       r_q;       // partial remainder
    logic [W-1:0]     q_q;       // dividend shifting out / quotient shifting in
    logic [W-1:0]     divisor_q; // latched divisor

    logic [W:0]       w_rs;
    logic [W:0]       w_diff;
    logic             w_borrow;
    logic [W:0]       r_d;
    logic [W-1:0]     q_d;

    // Shift the next dividend bit into the partial remainder
    assign w_rs = {r_q[W-1:0], q_q[W-1]};

    sub_borrow #(
        .N (W + 1)
    ) u_sub (
        .a_i      (w_rs),
        .b_i      ({1'b0, divisor_q}),
        .diff_o   (w_diff),
        .borrow_o (w_borrow)
    );

    // Restoring step: keep the difference only when it did not go negative
    always_comb begin
        r_d = w_rs;
        q_d = {q_q[W-2:0], 1'b0};
        if (!w_borrow) begin
            r_d = w_diff;
            q_d = {q_q[W-2:0], 1'b1};
        end
    end

    // The top bit of R is shifted out before it is ever read; after each
    // restoring step R < divisor so it carries no information.
    logic w_unused;
    assign w_unused = r_q[W];

    // Controller FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            divisor_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        divisor_q <= divisor;
                        r_q       <= '0;
                        q_q       <= dividend;
                        cnt_q     <= '0;
                        dbz_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        if (divisor == '0) begin
                            // No iterations needed: results are defined directly
                            state_q <= ST_DONE;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST_ITER) begin
                        // Final iteration: publish the results as DONE is entered
                        state_q <= ST_DONE;
                        quot_q  <= q_d;
                        rem_q   <= r_d[W-1:0];
                        done_q  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not sampled here
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule : restoring_divider4_ctrl
`default_nettype wire

// File: tb/tb_restoring_divider4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_restoring_divider4_ctrl
// Description : Self-checking bench for restoring_divider4_ctrl: directed
//               vector table, hand-written multi-cycle corner cases, an
//               exhaustive back-to-back sweep and random operations checked
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_restoring_divider4_ctrl;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a;
        int b;
        int eq;
        int er;
        int ez;
        int elat;
    } vec_t;

    vec_t vecs[10];

    restoring_divider4_ctrl #(
        .W (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Arithmetic reference: plain division, with the divide-by-zero rule
    task automatic model(input int a, input int b,
                         output int q, output int r, output int z, output int lat);
        if (b == 0) begin
            q = MAXV; r = a; z = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 0; lat = W + 1;
        end
    endtask

    // Called at a falling edge with the DUT idle. Latency is the number of
    // rising edges from the accepting edge up to the first edge at which
    // done is seen high.
    task automatic run_op(input int a, input int b, input int eq, input int er,
                          input int ez, input int elat, input bit ident);
        int lat;
        string tag;
        tag = $sformatf("%0d/%0d", a, b);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat = 0;
        for (int n = 0; n < 4 * W + 8; n++) begin
            if (done) begin
                lat = n + 1;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) begin
            chk({"done timeout ", tag}, 0, 1);
            return;
        end
        chk({"latency ", tag}, lat, elat);
        chk({"quotient ", tag}, int'(quotient), eq);
        chk({"remainder ", tag}, int'(remainder), er);
        chk({"div_by_zero ", tag}, int'(div_by_zero), ez);
        if (ident && b != 0) begin
            chk({"q*d+r ", tag}, int'(quotient) * b + int'(remainder), a);
            chk({"r<d ", tag}, int'(int'(remainder) < b), 1);
        end
        @(negedge clk);
        chk({"done single pulse ", tag}, int'(done), 0);
        chk({"idle after done ", tag}, int'(busy), 0);
        chk({"held quotient ", tag}, int'(quotient), eq);
        chk({"held remainder ", tag}, int'(remainder), er);
    endtask

    initial begin
        int q, r, z, lat, n, pulses, cq, cr;

        vecs[0] = '{13,  3,  4,  1, 0, 5};
        vecs[1] = '{15,  1, 15,  0, 0, 5};
        vecs[2] = '{ 2,  9,  0,  2, 0, 5};
        vecs[3] = '{ 7,  0, 15,  7, 1, 1};
        vecs[4] = '{ 8,  2,  4,  0, 0, 5};
        vecs[5] = '{ 9,  4,  2,  1, 0, 5};
        vecs[6] = '{ 0,  5,  0,  0, 0, 5};
        vecs[7] = '{15, 15,  1,  0, 0, 5};
        vecs[8] = '{ 0,  0, 15,  0, 1, 1};
        vecs[9] = '{14, 15,  0, 14, 0, 5};

        rst = 1'b1; start = 1'b1; dividend = 4'd5; divisor = 4'd1;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset div_by_zero", int'(div_by_zero), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-derived expectations
        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er,
                   vecs[i].ez, vecs[i].elat, 1'b0);

        // Start re-asserted with new operands during RUN cycle 2
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd5; divisor = 4'd5;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; cq = -1; cr = -1;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                pulses++;
                cq = int'(quotient);
                cr = int'(remainder);
            end
            @(negedge clk);
        end
        chk("reassert done pulses", pulses, 1);
        chk("reassert quotient", cq, 4);
        chk("reassert remainder", cr, 1);

        // Start held high: accepted again on the first IDLE cycle
        dividend = 4'd6; divisor = 4'd2; start = 1'b1;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("held start first done", int'(done), 1);
        chk("held start quotient", int'(quotient), 3);
        @(negedge clk);
        n = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("held start done spacing", n, W + 2);
        start = 1'b0;
        @(negedge clk);
        chk("held start idle", int'(busy), 0);

        // Reset in RUN cycle 3 aborts; next start accepted immediately
        dividend = 4'd11; divisor = 4'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort quotient", int'(quotient), 0);
        chk("abort remainder", int'(remainder), 0);
        chk("abort div_by_zero", int'(div_by_zero), 0);
        run_op(9, 4, 2, 1, 0, W + 1, 1'b1);

        // Exhaustive back-to-back sweep against the reference model
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                model(a, b, q, r, z, lat);
                run_op(a, b, q, r, z, lat, 1'b1);
            end
        end

        // Random operations with random idle gaps
        for (int i = 0; i < 120; i++) begin
            int a, b;
            a = int'($urandom_range(0, MAXV));
            b = int'($urandom_range(0, MAXV));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            model(a, b, q, r, z, lat);
            run_op(a, b, q, r, z, lat, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_restoring_divider4_ctrl
`default_nettype wire

// File: doc/restoring_divider4_ctrl.md
RESTORING_DIVIDER4_CTRL -- requirements
Module: restoring_divider4_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, W, numerator; latched on the accepted start.
REQ-006 SHALL have port divisor, input, W, denominator; latched on the accepted start.
REQ-007 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1, one-clock pulse marking valid results.
REQ-009 SHALL have port quotient, output, W, result quotient; held until the next accepted start.
REQ-010 SHALL have port remainder, output, W, result remainder; held until the next accepted start.
REQ-011 SHALL have port div_by_zero, output, 1, flag for divisor==0 on the last operation; held with the results.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1, latch the operands, clear partial remainder R (W+1 bits), load Q=dividend and clear iteration counter cnt, then go to RUN; in the same cycle it SHALL clear div_by_zero.
REQ-014 SHALL, in IDLE with start=1 and divisor==0, go directly to DONE with quotient=all-ones, remainder=dividend and div_by_zero=1.
REQ-015 SHALL, in each RUN cycle: form Rs={R[W-1:0],Q[W-1]}, compute D=Rs-{0,divisor} with the shared subtractor, and use its borrow.
  - borrow=0: R<=D, Q<={Q[W-2:0],1}.
  - borrow=1: R<=Rs, Q<={Q[W-2:0],0}.
REQ-016 SHALL increment cnt each RUN cycle and leave RUN for DONE after exactly W iterations; cnt SHALL be ceil(log2(W))+1 bits and never wrap inside RUN.
REQ-017 SHALL, on entering DONE, drive quotient=Q and remainder=R[W-1:0]; in DONE, done=1 for exactly one clock, then return to IDLE.
REQ-018 SHALL give a latency of W+1 clocks from the start-sampling edge to the done pulse (1 clock for divide by zero).
REQ-019 SHALL ignore start while busy=1, including in the DONE cycle; a start held high is accepted again on the first IDLE cycle.
REQ-020 SHALL ignore changes on dividend/divisor after acceptance.
REQ-021 SHALL guarantee remainder<divisor and quotient*divisor+remainder==dividend for every nonzero divisor.

Reset
REQ-022 SHALL, when rst=1 at a clock edge, force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, cnt=0 and R=0, with rst taking priority over start.
REQ-023 SHALL, on reset during RUN or DONE, abort the operation with no done pulse, and accept start from the first cycle after rst deasserts.

Structure
REQ-024 SHALL place the state enum (IDLE/RUN/DONE), default W and the iteration-count width in a shared package div_pkg.
REQ-025 SHALL instantiate one combinational sub-module sub_borrow (W+1-bit A-B giving difference and borrow, built as a ripple of 1-bit full subtractors), used once per cycle.

Verification
REQ-026 SHALL cover: 13/3, start pulsed at edge k -> done at cycle k+5, quotient=4, remainder=1, div_by_zero=0.
REQ-027 SHALL cover: 15/1 -> quotient=15, remainder=0; then 2/9 -> quotient=0, remainder=2.
REQ-028 SHALL cover: 7/0 -> done one clock after start, quotient=15, remainder=7, div_by_zero=1; a following 8/2 clears the flag, giving 4, 0.
REQ-029 SHALL cover: start reasserted with new operands on RUN cycle 2 -> ignored; the first result is unchanged and only one done pulse occurs.
REQ-030 SHALL cover: rst=1 in RUN cycle 3 -> next cycle IDLE with all outputs 0 and no done; a fresh 9/4 then gives 2, 1.
REQ-031 SHALL cover: exhaustive 256-pair sweep with back-to-back starts, checking REQ-021 and the latency against a reference model.
